julia_wr_arb: RTL

Parametrised pixel write arbiter between the array of Julia-set pixel engines and the frame-buffer write port. Each cycle it captures at most one finished pixel from the `done` engines, chosen round-robin, and releases that engine. It buffers captured pixels in a small FIFO. It drains the FIFO to memory over a write port that fully honours `wait_request`, at up to one write per cycle.

---
 rtl/julia_pkg.sv | 24 ++
 rtl/julia_wr_fifo.sv | 57 +++++
 rtl/julia_wr_arb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/julia_pkg.sv
// julia_pkg: shared types and default sizes for the Julia-set pixel write path.
//   wr_state_t  - write-port bus FSM states
//   pix_entry_t - capture FIFO entry {addr, data} at the default widths
//   Def*        - default parameter values used by julia_wr_arb
package julia_pkg;

  localparam int unsigned DefNumEngines = 16;
  localparam int unsigned DefAddrW      = 32;
  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefFifoDepth  = 4;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } wr_state_t;

  // Default-width view of a FIFO entry; the FIFO itself stores {addr, data}
  // as a flat vector so non-default widths still work.
  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/julia_wr_fifo.sv
// julia_wr_fifo: synchronous show-ahead FIFO buffering captured pixels.
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write an entry (ignored when full)
//   pop           - discard the head entry (ignored when empty)
//   full, empty   - occupancy flags from the current count
//   count         - current number of entries
//   head          - oldest entry, valid whenever empty is low
module julia_wr_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count,
  output logic [Width-1:0]         head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/julia_wr_arb.sv
// julia_wr_arb: round-robin pixel capture from the engine array plus a
// wait_request-honouring frame-buffer write port fed from a small FIFO.
//   clk, rst                 - clock, synchronous active-high reset
//   cat_addr, cat_pixel      - per-engine address/pixel, engine i at [i*W +: W]
//   done                     - engine i holds a finished pixel (level)
//   free                     - one-hot pulse: engine i's pixel was captured
//   wait_request             - memory stall
//   write_address/data/enable - memory write request (addr/data 0 when idle)
// Optional: define JULIA_WR_ARB_STATS_EN to add pixels_written (wrapping) and
// stall_cycles (saturating) counters.
module julia_wr_arb
  import julia_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = DefNumEngines,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W*NUM_ENGINES-1:0] cat_addr,
  input  logic [DATA_W*NUM_ENGINES-1:0] cat_pixel,
  input  logic [NUM_ENGINES-1:0]        done,
  output logic [NUM_ENGINES-1:0]        free,
  input  logic                          wait_request,
  output logic [ADDR_W-1:0]             write_address,
  output logic [DATA_W-1:0]             write_data,
  output logic                          write_enable
`ifdef JULIA_WR_ARB_STATS_EN
  ,
  output logic [31:0]                   pixels_written,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(NUM_ENGINES);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]      addr_arr [NUM_ENGINES];
  logic [DATA_W-1:0]      pix_arr  [NUM_ENGINES];

  logic [PtrW-1:0]        ptr_q;
  logic [NUM_ENGINES-1:0] free_q;
  logic [NUM_ENGINES-1:0] eligible;
  logic                   grant_vld;
  logic [PtrW-1:0]        grant_idx;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CntW-1:0]        fifo_count;
  logic [EntW-1:0]        fifo_head;
  logic                   complete;

  wr_state_t              state_q;
  logic                   we_q;

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_unpack
    assign addr_arr[i] = cat_addr[i*ADDR_W +: ADDR_W];
    assign pix_arr[i]  = cat_pixel[i*DATA_W +: DATA_W];
  end

  // Last cycle's grant is exactly free_q; masking it hides the cycle an engine
  // needs to drop done after seeing its free pulse.
  always_comb begin
    int unsigned     idx;
    logic [PtrW-1:0] idx_w;
    eligible  = done & ~free_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_ENGINES) idx = idx - NUM_ENGINES;
      idx_w = PtrW'(idx);
      if (!grant_vld && eligible[idx_w]) begin
        grant_vld = 1'b1;
        grant_idx = idx_w;
      end
    end
    // Full is judged at the start of the cycle; a same-cycle pop does not help.
    if (fifo_full) grant_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      free_q <= '0;
    end else begin
      free_q <= '0;
      if (grant_vld) begin
        free_q[grant_idx] <= 1'b1;
        ptr_q <= (grant_idx == PtrW'(NUM_ENGINES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  julia_wr_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_vld),
    .wdata ({addr_arr[grant_idx], pix_arr[grant_idx]}),
    .pop   (complete),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign complete = we_q & ~wait_request;

  // A push this cycle lets IDLE enter WRITE so the pixel is driven next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty || grant_vld) begin
            state_q <= StWrite;
            we_q    <= 1'b1;
          end
        end
        StWrite: begin
          if (!wait_request && !(fifo_count > CntW'(1)) && !grant_vld) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign free          = free_q;
  assign write_enable  = we_q;
  assign write_address = we_q ? fifo_head[EntW-1:DATA_W] : '0;
  assign write_data    = we_q ? fifo_head[DATA_W-1:0]    : '0;

`ifdef JULIA_WR_ARB_STATS_EN
  logic [31:0] pix_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (complete) pix_cnt_q <= pix_cnt_q + 32'd1;
      if (we_q && wait_request && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign pixels_written = pix_cnt_q;
  assign stall_cycles   = stall_cnt_q;
`endif

endmodule
